// File: rtl/hazard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_pkg                                                               |
// | Forward-select encodings, shadow stage entry type and match helpers.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hazard_pkg;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_E     = 2'd1;
   localparam logic [1:0] FWD_M     = 2'd2;
   localparam logic [1:0] FWD_W     = 2'd3;
   localparam logic [1:0] TNEW_NONE = 2'd0;

   typedef struct packed {
      logic [4:0] a1;
      logic [4:0] a2;
      logic [4:0] a3;
      logic [1:0] tnew;
   } stage_t;

   localparam stage_t c_bubble = '0;

   // Saturating decrement: a finished result stays finished.
   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == TNEW_NONE) ? TNEW_NONE : t - 2'd1;
   endfunction

   function automatic logic src_match(input logic [4:0] a, input stage_t s);
      return (a != 5'd0) && (s.a3 == a);
   endfunction

   function automatic logic src_stall(input logic [4:0] a, input logic [1:0] tuse,
                                      input stage_t s);
      return src_match(a, s) && (s.tnew > tuse);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_fwd_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fwd_sel                                                                  |
// | Youngest-first forwarding select over the E/M/W shadow entries.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fwd_sel
   import hazard_pkg::*;
#(
   parameter logic [2:0] EN_MASK = 3'b111   // {W, M, E} stages this consumer may use
) (
   input  logic [4:0] src,
   input  stage_t     e_ent,
   input  stage_t     m_ent,
   input  stage_t     w_ent,
   output logic [1:0] sel
);

   // Only destination/tnew fields take part in forwarding decisions.
   logic w_unused;
   assign w_unused = ^{e_ent.a1, e_ent.a2, m_ent.a1, m_ent.a2, w_ent.a1, w_ent.a2};

   always_comb begin
      sel = FWD_RF;
      if (EN_MASK[0] && src_match(src, e_ent) && (e_ent.tnew == TNEW_NONE))
         sel = FWD_E;
      else if (EN_MASK[1] && src_match(src, m_ent) && (m_ent.tnew == TNEW_NONE))
         sel = FWD_M;
      else if (EN_MASK[2] && src_match(src, w_ent) && (w_ent.tnew == TNEW_NONE))
         sel = FWD_W;
   end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_unit                                                              |
// | Stall and forwarding control from D-stage use/new info and E/M/W shadows. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_unit
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] d_a1,
   input  logic [1:0] d_tuse1,
   input  logic [4:0] d_a2,
   input  logic [1:0] d_tuse2,
   input  logic [4:0] d_a3,
   input  logic [1:0] d_tnew,
   input  logic       d_mdureq,
   input  logic       mdu_busy,
   input  logic       mdu_start,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fwd_d1,
   output logic [1:0] fwd_d2,
   output logic [1:0] fwd_e1,
   output logic [1:0] fwd_e2,
   output logic [1:0] fwd_m2
);

   stage_t r_e;
   stage_t r_m;
   stage_t r_w;
   stage_t w_d;
   logic   w_data_stall;
   logic   w_mdu_stall;
   logic   w_stall;

   assign w_d = '{a1: d_a1, a2: d_a2, a3: d_a3, tnew: d_tnew};

   // W is never consulted: anything there is already readable by forwarding.
   assign w_data_stall = src_stall(d_a1, d_tuse1, r_e) || src_stall(d_a1, d_tuse1, r_m) ||
                         src_stall(d_a2, d_tuse2, r_e) || src_stall(d_a2, d_tuse2, r_m);
   assign w_mdu_stall  = d_mdureq && (mdu_busy || mdu_start);
   assign w_stall      = w_data_stall || w_mdu_stall;
   assign stall        = w_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e <= c_bubble;
         r_m <= c_bubble;
         r_w <= c_bubble;
      end else if (flush) begin
         r_e <= c_bubble;
         r_m <= c_bubble;
         r_w <= c_bubble;
      end else begin
         r_e <= w_stall ? c_bubble
                        : '{a1: w_d.a1, a2: w_d.a2, a3: w_d.a3, tnew: tnew_dec(w_d.tnew)};
         r_m <= '{a1: 5'd0, a2: r_e.a2, a3: r_e.a3, tnew: tnew_dec(r_e.tnew)};
         r_w <= '{a1: 5'd0, a2: 5'd0, a3: r_m.a3, tnew: tnew_dec(r_m.tnew)};
      end
   end

   fwd_sel #(.EN_MASK(3'b111)) u_fwd_d1 (
      .src(d_a1), .e_ent(r_e), .m_ent(r_m), .w_ent(r_w), .sel(fwd_d1)
   );
   fwd_sel #(.EN_MASK(3'b111)) u_fwd_d2 (
      .src(d_a2), .e_ent(r_e), .m_ent(r_m), .w_ent(r_w), .sel(fwd_d2)
   );
   fwd_sel #(.EN_MASK(3'b110)) u_fwd_e1 (
      .src(r_e.a1), .e_ent(r_e), .m_ent(r_m), .w_ent(r_w), .sel(fwd_e1)
   );
   fwd_sel #(.EN_MASK(3'b110)) u_fwd_e2 (
      .src(r_e.a2), .e_ent(r_e), .m_ent(r_m), .w_ent(r_w), .sel(fwd_e2)
   );
   fwd_sel #(.EN_MASK(3'b100)) u_fwd_m2 (
      .src(r_m.a2), .e_ent(r_e), .m_ent(r_m), .w_ent(r_w), .sel(fwd_m2)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hazard_unit                                                           |
// | Directed pipeline vectors plus randomized run against an age model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_unit;
   import hazard_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] d_a1, d_a2, d_a3;
   logic [1:0] d_tuse1, d_tuse2, d_tnew;
   logic       d_mdureq, mdu_busy, mdu_start, flush;
   logic       stall;
   logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk(clk), .rst_n(rst_n),
      .d_a1(d_a1), .d_tuse1(d_tuse1), .d_a2(d_a2), .d_tuse2(d_tuse2),
      .d_a3(d_a3), .d_tnew(d_tnew), .d_mdureq(d_mdureq),
      .mdu_busy(mdu_busy), .mdu_start(mdu_start), .flush(flush),
      .stall(stall), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2),
      .fwd_e1(fwd_e1), .fwd_e2(fwd_e2), .fwd_m2(fwd_m2)
   );

   typedef struct {
      logic [4:0] a1; logic [1:0] t1; logic [4:0] a2; logic [1:0] t2;
      logic [4:0] a3; logic [1:0] tn;
      logic mr, bz, st, fl;
      logic [10:0] exp;   // {stall, d1, d2, e1, e2, m2}
   } vec_t;

   vec_t vecs[41];

   function automatic vec_t mk(int a1, int t1, int a2, int t2, int a3, int tn,
                               int mr, int bz, int st, int fl,
                               int xs, int xd1, int xd2, int xe1, int xe2, int xm2);
      vec_t v;
      v.a1 = 5'(a1); v.t1 = 2'(t1); v.a2 = 5'(a2); v.t2 = 2'(t2);
      v.a3 = 5'(a3); v.tn = 2'(tn);
      v.mr = 1'(mr); v.bz = 1'(bz); v.st = 1'(st); v.fl = 1'(fl);
      v.exp = {1'(xs), 2'(xd1), 2'(xd2), 2'(xe1), 2'(xe2), 2'(xm2)};
      return v;
   endfunction

   task automatic drive(input vec_t v);
      d_a1 = v.a1; d_tuse1 = v.t1; d_a2 = v.a2; d_tuse2 = v.t2;
      d_a3 = v.a3; d_tnew = v.tn;
      d_mdureq = v.mr; mdu_busy = v.bz; mdu_start = v.st; flush = v.fl;
   endtask

   function automatic logic [10:0] outs();
      return {stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2};
   endfunction

   task automatic check(input string name, input int idx, input logic [10:0] exp);
      logic [10:0] got;
      got = outs();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got {stall,d1,d2,e1,e2,m2}=%b, expected %b", name, idx, got, exp);
      end
   endtask

   // Reference model: each in-flight instruction keeps its D-stage tnew; its
   // remaining latency in stage k (1=E,2=M,3=W) is max(tnew - k, 0).
   typedef struct { int a1; int a2; int a3; int t0; } rec_t;
   rec_t pipe[1:3];

   function automatic int remain(rec_t r, int k);
      return (r.t0 > k) ? r.t0 - k : 0;
   endfunction

   function automatic bit hits(int a, rec_t r);
      return (a != 0) && (r.a3 == a);
   endfunction

   // Select code for stage k is k itself (E=1, M=2, W=3), RF=0.
   function automatic int pick(int a, int youngest);
      for (int k = youngest; k <= 3; k++)
         if (hits(a, pipe[k]) && remain(pipe[k], k) == 0) return k;
      return 0;
   endfunction

   function automatic logic [10:0] model();
      bit s;
      int src[2];
      int tu[2];
      src[0] = int'(d_a1); tu[0] = int'(d_tuse1);
      src[1] = int'(d_a2); tu[1] = int'(d_tuse2);
      s = d_mdureq && (mdu_busy || mdu_start);
      for (int i = 0; i < 2; i++)
         for (int k = 1; k <= 2; k++)
            if (hits(src[i], pipe[k]) && remain(pipe[k], k) > tu[i]) s = 1;
      return {s, 2'(pick(src[0], 1)), 2'(pick(src[1], 1)),
              2'(pick(pipe[1].a1, 2)), 2'(pick(pipe[1].a2, 2)), 2'(pick(pipe[2].a2, 3))};
   endfunction

   initial begin
      vec_t nop;
      logic [10:0] e;
      nop = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
      // addu $1 -> addu $2,$1,$3 -> W-only read of $1
      vecs[0]  = nop;
      vecs[1]  = mk(4,1,5,1,1,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[2]  = mk(1,1,3,1,2,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[3]  = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,2,0,0);
      vecs[4]  = mk(1,0,0,0,0,0, 0,0,0,0, 0,3,0,0,0,0);
      vecs[5]  = nop; vecs[6] = nop;
      // lw $1 -> addu $2,$1,$3 : one-cycle load-use stall
      vecs[7]  = mk(29,1,0,0,1,3, 0,0,0,0, 0,0,0,0,0,0);
      vecs[8]  = mk(1,1,3,1,2,2, 0,0,0,0, 1,0,0,0,0,0);
      vecs[9]  = mk(1,1,3,1,2,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[10] = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,3,0,0);
      vecs[11] = nop; vecs[12] = nop;
      // addu $1 -> beq $1,$0
      vecs[13] = mk(4,1,5,1,1,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[14] = mk(1,0,0,0,0,0, 0,0,0,0, 1,0,0,0,0,0);
      vecs[15] = mk(1,0,0,0,0,0, 0,0,0,0, 0,2,0,0,0,0);
      vecs[16] = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,3,0,0);
      vecs[17] = nop;
      // jal -> jr $31
      vecs[18] = mk(0,0,0,0,31,1, 0,0,0,0, 0,0,0,0,0,0);
      vecs[19] = mk(31,0,0,0,0,0, 0,0,0,0, 0,1,0,0,0,0);
      vecs[20] = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,2,0,0);
      vecs[21] = nop; vecs[22] = nop;
      // mflo behind mult: start cycle plus five busy cycles
      vecs[23] = mk(0,0,0,0,8,2, 1,0,1,0, 1,0,0,0,0,0);
      for (int i = 24; i <= 28; i++) vecs[i] = mk(0,0,0,0,8,2, 1,1,0,0, 1,0,0,0,0,0);
      vecs[29] = mk(0,0,0,0,8,2, 1,0,0,0, 0,0,0,0,0,0);
      vecs[30] = mk(0,0,0,0,9,2, 0,1,0,0, 0,0,0,0,0,0);
      vecs[31] = nop; vecs[32] = nop; vecs[33] = nop;
      // flush during a load-use stall
      vecs[34] = mk(29,1,0,0,1,3, 0,0,0,0, 0,0,0,0,0,0);
      vecs[35] = mk(1,1,3,1,2,2, 0,0,0,1, 1,0,0,0,0,0);
      vecs[36] = mk(1,1,3,1,2,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[37] = nop;
      // write $0 then read $0
      vecs[38] = mk(4,1,5,1,0,2, 0,0,0,0, 0,0,0,0,0,0);
      vecs[39] = mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0);
      vecs[40] = nop;

      drive(nop);
      @(negedge clk);
      check("reset", 0, 11'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 41; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check("vec", i, vecs[i].exp);
         @(posedge clk); #1;
      end

      // Async reset in the middle of a load-use stall
      drive(mk(29,1,0,0,1,3, 0,0,0,0, 0,0,0,0,0,0));
      @(posedge clk); #1;
      drive(mk(1,1,3,1,2,2, 0,0,0,0, 0,0,0,0,0,0));
      @(negedge clk);
      check("rst_pre", 0, {1'b1, 10'd0});
      #2 rst_n = 1'b0;
      #1 check("rst_async", 0, 11'd0);
      @(posedge clk); #1;
      check("rst_held", 0, 11'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("rst_release", 0, 11'd0);
      @(posedge clk); #1;

      // Randomized run from a clean state
      drive(nop);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         d_a1 = 5'($urandom_range(0, 3)); d_tuse1 = 2'($urandom_range(0, 3));
         d_a2 = 5'($urandom_range(0, 3)); d_tuse2 = 2'($urandom_range(0, 3));
         d_a3 = 5'($urandom_range(0, 3)); d_tnew = 2'($urandom_range(0, 3));
         d_mdureq  = ($urandom_range(0, 3) == 0);
         mdu_busy  = ($urandom_range(0, 2) == 0);
         mdu_start = ($urandom_range(0, 4) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         e = model();
         check("rand", c, e);
         if (flush) begin
            for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
         end else begin
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            if (e[10]) pipe[1] = '{0, 0, 0, 0};
            else       pipe[1] = '{int'(d_a1), int'(d_a2), int'(d_a3), int'(d_tnew)};
         end
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
